normalizer: RTL and testbench
=============================

NORMALIZER -- requirements
Module: normalizer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: in_valid  input  1  upstream presents a raw sum.
REQ-004 SHALL have port: in_ready  output  1  block can accept a raw sum this cycle.
REQ-005 SHALL have port: in_sign  input  1  sign of the raw sum.
REQ-006 SHALL have port: in_exponent  input  8  common (aligned) exponent.
REQ-007 SHALL have port: in_mantissa  input  25  raw sum; bit 24 = carry, bit 23 = hidden-bit position.
REQ-008 SHALL have port: out_valid  output  1  packed result available.
REQ-009 SHALL have port: out_ready  input  1  downstream accepts the result.
REQ-010 SHALL have port: out_result  output  32  packed IEEE-754 single: {sign, exponent[7:0], fraction[22:0]}.

Function
REQ-011 SHALL implement FSM states IDLE, NORM, DONE; in_ready = 1 only in IDLE.
REQ-012 SHALL, in IDLE, on in_valid & in_ready capture sign, exponent and mantissa into working registers and move to NORM.
REQ-013 SHALL, in NORM when mantissa == 0, produce {sign, 8'd0, 23'd0} and move to DONE.
REQ-014 SHALL, in NORM when mantissa[24] = 1, shift the mantissa right by 1 (truncating, no rounding), increment the exponent, and move to DONE.
REQ-015 SHALL, in NORM when mantissa[24:23] = 2'b01, move to DONE without change.
REQ-016 SHALL, in NORM otherwise, shift the mantissa left by 1, decrement the exponent, and remain in NORM (one bit per cycle).
REQ-017 SHALL assert out_valid in DONE with out_result = {sign, exponent, mantissa[22:0]}.
REQ-018 SHALL hold out_result stable while out_valid & !out_ready, and return to IDLE on out_valid & out_ready.
REQ-019 SHALL have latency: out_valid two cycles after the accept edge for carry, already-normal or zero inputs, plus one cycle per left shift (max 23 left shifts, 25 cycles).
REQ-020 SHALL ignore in_valid outside IDLE and SHALL NOT accept a new input in the cycle DONE is left.

Reset
REQ-021 SHALL, while reset is high, force state IDLE, in_ready = 0, out_valid = 0 and out_result = 32'h0, and clear the working registers.
REQ-022 SHALL drive in_ready = 1 from the first cycle after reset deasserts.
REQ-023 SHALL, on reset in NORM or DONE, discard the in-flight operation with no output produced.

Configuration
REQ-024 SHALL, with NORMALIZER_SATURATE_EN defined, output {sign, 8'hFF, 23'd0} (infinity) when a carry increment starts from exponent 8'hFF or reaches it.
REQ-025 SHALL, with NORMALIZER_SATURATE_EN defined, output {sign, 8'd0, 23'd0} when a left shift would take the exponent to 0 or wrap it below 0.
REQ-026 SHALL, without NORMALIZER_SATURATE_EN, have the exponent wrap modulo 256 in both directions, with no special-casing.

Structure
REQ-027 SHALL take from shared package fp_pkg: typedef fp32_t (packed struct sign/exponent/fraction), EXP_W = 8, FRAC_W = 23, EXP_MAX = 8'hFF, and the state enum type.
REQ-028 SHALL be a single module with no sub-module; the shift/exponent datapath and the FSM stay inline.

Verification
REQ-029 SHALL cover: sign 0, exp 127, mant 25'h1000000 -> out_result 32'h40000000, out_valid 2 cycles after accept.
REQ-030 SHALL cover: sign 0, exp 127, mant 25'h0400000 -> 32'h3F000000 after 3 cycles; and mant 25'h0000001 -> 32'h34000000 after 25 cycles.
REQ-031 SHALL cover: sign 1, exp 100, mant 25'h0 -> 32'h80000000 after 2 cycles.
REQ-032 SHALL cover: exp 255, mant 25'h1000000 -> 32'h7F800000 with the macro, 32'h00000000 without; and exp 0, mant 25'h0400000 -> 32'h00000000 with the macro, 32'h7F800000 without.
REQ-033 SHALL cover: out_ready held low for 5 cycles in DONE -> out_result stable, in_ready = 0; and in_valid pulsed meanwhile -> ignored.
REQ-034 SHALL cover: reset asserted mid-NORM -> next cycle IDLE, out_valid = 0, out_result = 0, no stale result emitted.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared single-precision types and constants
// used by the normalizer and neighbouring FP stages.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = FRAC_W + 2;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  localparam logic [MANT_W-1:0] MANT_HIDDEN = 25'h0800000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exponent;
    logic [FRAC_W-1:0] fraction;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } norm_state_t;

endpackage

// File: rtl/normalizer.sv
// normalizer: post-add mantissa normalizer, one shift per cycle.
// Optional NORMALIZER_SATURATE_EN clamps exponent over/underflow.
module normalizer
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exponent,
  input  logic [24:0] in_mantissa,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result
);

  norm_state_t state_q;
  norm_state_t state_d;

  logic              sign_q;
  logic              sign_d;
  logic [EXP_W-1:0]  exp_q;
  logic [EXP_W-1:0]  exp_d;
  logic [MANT_W-1:0] mant_q;
  logic [MANT_W-1:0] mant_d;

  logic [EXP_W-1:0]  exp_inc;
  logic [EXP_W-1:0]  exp_dec;
  logic              accept;
  logic              mant_zero;
  logic              mant_carry;
  logic              mant_norm;
  logic              sat_hi;
  logic              sat_lo;
  fp32_t             packed_res;

  assign accept     = in_valid & in_ready;
  assign exp_inc    = exp_q + 8'd1;
  assign exp_dec    = exp_q - 8'd1;
  assign mant_zero  = (mant_q == '0);
  assign mant_carry = mant_q[24];
  assign mant_norm  = (mant_q[24:23] == 2'b01);

`ifdef NORMALIZER_SATURATE_EN
  assign sat_hi = (exp_q == EXP_MAX) ||
                  (exp_inc == EXP_MAX);
  assign sat_lo = (exp_q == '0) ||
                  (exp_dec == '0);
`else
  assign sat_hi = 1'b0;
  assign sat_lo = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = NORM;
      end
      NORM: begin
        unique case (1'b1)
          mant_zero:  state_d = DONE;
          mant_carry: state_d = DONE;
          mant_norm:  state_d = DONE;
          default: begin
            if (sat_lo) state_d = DONE;
          end
        endcase
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // working-register next values: capture, then shift/adjust
  always_comb begin
    sign_d = sign_q;
    exp_d  = exp_q;
    mant_d = mant_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sign_d = in_sign;
          exp_d  = in_exponent;
          mant_d = in_mantissa;
        end
      end
      NORM: begin
        unique case (1'b1)
          mant_zero: begin
            exp_d = '0;
          end
          mant_carry: begin
            if (sat_hi) begin
              exp_d  = EXP_MAX;
              mant_d = MANT_HIDDEN;
            end else begin
              exp_d  = exp_inc;
              mant_d = {1'b0, mant_q[24:1]};
            end
          end
          mant_norm: begin
            mant_d = mant_q;
          end
          default: begin
            if (sat_lo) begin
              exp_d  = '0;
              mant_d = '0;
            end else begin
              exp_d  = exp_dec;
              mant_d = {mant_q[23:0], 1'b0};
            end
          end
        endcase
      end
      default: begin
        mant_d = mant_q;
      end
    endcase
  end

  // working registers; cleared on reset so no stale result survives
  always_ff @(posedge clk) begin
    if (reset) begin
      sign_q <= 1'b0;
      exp_q  <= '0;
      mant_q <= '0;
    end else begin
      sign_q <= sign_d;
      exp_q  <= exp_d;
      mant_q <= mant_d;
    end
  end

  // outputs, held at zero while reset is asserted
  always_comb begin
    packed_res.sign     = sign_q;
    packed_res.exponent = exp_q;
    packed_res.fraction = mant_q[FRAC_W-1:0];
    in_ready   = !reset && (state_q == IDLE);
    out_valid  = !reset && (state_q == DONE);
    out_result = out_valid ? packed_res : 32'h0;
  end

endmodule

// File: tb/tb_normalizer.sv
// tb_normalizer: randomized + directed bench with a
// behavioural model of mantissa normalization.
module tb_normalizer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exponent = 8'd0;
  logic [24:0] in_mantissa = 25'd0;
  logic        out_ready = 1'b1;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_result;

  normalizer dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_exponent (in_exponent),
    .in_mantissa (in_mantissa),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   seen = 1'b0;
  bit   rnd_ready = 1'b0;
  exp_t pend[$];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, req);
  endtask

  // reference: normalize by plain arithmetic on integers
  function automatic exp_t model(bit s, logic [7:0] e,
                                 logic [24:0] m);
    exp_t r;
    int ex;
    logic [24:0] mm;
    bit sat;
`ifdef NORMALIZER_SATURATE_EN
    sat = 1'b1;
`else
    sat = 1'b0;
`endif
    ex = int'(e);
    mm = m;
    r.lat = 2;
    if (mm == 0) begin
      r.res = {s, 31'b0};
      return r;
    end
    if (mm[24]) begin
      ex = ex + 1;
      mm = mm >> 1;
      if (sat && ex >= 255) r.res = {s, 8'hFF, 23'b0};
      else r.res = {s, 8'(ex % 256), mm[22:0]};
      return r;
    end
    while (!mm[23]) begin
      if (sat && ex - 1 <= 0) begin
        r.res = {s, 31'b0};
        return r;
      end
      mm = mm << 1;
      ex = ex - 1;
      r.lat++;
    end
    r.res = {s, 8'(((ex % 256) + 256) % 256), mm[22:0]};
    return r;
  endfunction

  // edge bookkeeping: accept time and result consumption
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      pend.delete();
      seen = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_cyc = cyc;
      if (out_valid && out_ready) begin
        if (pend.size() > 0) void'(pend.pop_front());
        seen = 1'b0;
      end
    end
  end

  // compare process: every cycle a result is presented
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (pend.size() == 0) begin
        chk("spurious_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        if (!seen) begin
          chk("latency", cyc + 1 - acc_cyc, pend[0].lat);
          seen = 1'b1;
        end
        chk("result", out_result, pend[0].res);
        chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(bit s, logic [7:0] e, logic [24:0] m,
                      logic [31:0] res, int lat);
    exp_t x;
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
      return;
    end
    x.res = res;
    x.lat = lat;
    pend.push_back(x);
    in_sign     = s;
    in_exponent = e;
    in_mantissa = m;
    in_valid    = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_model(bit s, logic [7:0] e,
                            logic [24:0] m);
    exp_t r;
    r = model(s, e, m);
    send(s, e, m, r.res, r.lat);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (pend.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (pend.size() > 0) begin
      chk("done_timeout", pend.size(), 0);
      pend.delete();
    end
  endtask

  exp_t r;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, in_ready}, 32'd1);

    r = model(1'b0, 8'd127, 25'h1000000);
    chk("model_carry", r.res, 32'h40000000);
    chk("model_carry_lat", r.lat, 2);
    r = model(1'b0, 8'd127, 25'h0000001);
    chk("model_lsb", r.res, 32'h34000000);
    chk("model_lsb_lat", r.lat, 25);
    r = model(1'b1, 8'd100, 25'h0);
    chk("model_zero", r.res, 32'h80000000);

    send(0, 8'd127, 25'h1000000, 32'h40000000, 2);
    wait_idle();
    send(0, 8'd127, 25'h0400000, 32'h3F000000, 3);
    wait_idle();
    send(0, 8'd127, 25'h0000001, 32'h34000000, 25);
    wait_idle();
    send(1, 8'd100, 25'h0, 32'h80000000, 2);
    wait_idle();
`ifdef NORMALIZER_SATURATE_EN
    send(0, 8'd255, 25'h1000000, 32'h7F800000, 2);
    wait_idle();
    send(0, 8'd0, 25'h0400000, 32'h00000000, 2);
    wait_idle();
`else
    send(0, 8'd255, 25'h1000000, 32'h00000000, 2);
    wait_idle();
    send(0, 8'd0, 25'h0400000, 32'h7F800000, 3);
    wait_idle();
`endif

    // backpressure: hold DONE 5 cycles, poke in_valid meanwhile
    out_ready = 1'b0;
    send(0, 8'd130, 25'h0C00000, 32'h41400000, 2);
    for (int i = 0; i < 20 && !out_valid; i++)
      @(negedge clk);
    chk("stall_valid", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid    = i[0];
      in_mantissa = 25'h1000000;
      in_exponent = 8'd3;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    // reset during NORM drops the operation
    send(0, 8'd127, 25'h0000001, 32'h34000000, 25);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_result", out_result, 32'h0);
    chk("midrst_ready", {31'b0, in_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_idle", {31'b0, in_ready}, 32'd1);
    repeat (30) @(negedge clk);

    rnd_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [24:0] m;
      logic [7:0]  e;
      bit          s;
      s = 1'($urandom);
      e = 8'($urandom);
      case ($urandom_range(0, 3))
        0: m = 25'h0;
        1: m = 25'h1000000 | 25'($urandom);
        2: m = 25'h0800000 | (25'($urandom) & 25'h07FFFFF);
        default: m = (25'($urandom) & 25'h0FFFFFF)
                     >> $urandom_range(0, 23);
      endcase
      send_model(s, e, m);
    end
    wait_idle();
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
